// File: rtl/pe_tile_sequencer.sv
// Tile sequencer for one PE row: accepts a multi-tile job, issues one start per tile,
// gathers per-column confEnd pulses, forwards downstream stall and reports completion.
module pe_tile_sequencer #(
  parameter int NPE     = 4,
  parameter int NTILEWD = 8
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  // job descriptor handshake
  input  logic               Job_rdy,
  output logic               Job_ack,
  input  logic [NTILEWD-1:0] i_job_ntile,
  // PE row status and control
  input  logic [NPE-1:0]     i_confEnd,
  input  logic               i_stall_req,
  input  logic               i_abort,
  // shared PE instruction bundle
  output logic               o_inst_dval,
  output logic               o_inst_start,
  output logic               o_inst_reset,
  output logic               o_inst_next,
  output logic               o_inst_stall,
  output logic [NTILEWD-1:0] o_tile_idx,
  output logic               o_busy,
  // completion handshake
  output logic               Done_rdy,
  input  logic               Done_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_RELOAD,
    S_DONE,
    S_ABORT
  } state_e;

  state_e             state_q,    state_d;
  logic [NTILEWD-1:0] ntile_q,    ntile_d;
  logic [NTILEWD-1:0] tile_idx_q, tile_idx_d;
  logic [NPE-1:0]     end_seen_q, end_seen_d;

  logic job_xfer;
  logic tile_done;
  logic last_tile;

  assign job_xfer  = Job_rdy && (state_q == S_IDLE);
  // A column ending in the same cycle as the last missing one still counts.
  assign tile_done = &(end_seen_q | i_confEnd);
  // ntile is never 0 outside IDLE/DONE, so ntile-1 cannot underflow where it is used.
  assign last_tile = (tile_idx_q == (ntile_q - NTILEWD'(1)));

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      ntile_q    <= '0;
      tile_idx_q <= '0;
      end_seen_q <= '0;
    end else begin
      state_q    <= state_d;
      ntile_q    <= ntile_d;
      tile_idx_q <= tile_idx_d;
      end_seen_q <= end_seen_d;
    end
  end

  // NOTE: every signal written here gets a default first; a branch that forgets one
  // would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    ntile_d      = ntile_q;
    tile_idx_d   = tile_idx_q;
    end_seen_d   = end_seen_q;
    Job_ack      = 1'b0;
    Done_rdy     = 1'b0;
    o_inst_dval  = 1'b0;
    o_inst_start = 1'b0;
    o_inst_reset = 1'b0;
    o_inst_stall = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        Job_ack = 1'b1;
        if (job_xfer) begin
          ntile_d    = i_job_ntile;
          tile_idx_d = '0;
          state_d    = (i_job_ntile == '0) ? S_DONE : S_START;
        end
      end

      S_START, S_RELOAD: begin
        o_inst_dval  = 1'b1;
        o_inst_start = 1'b1;
        end_seen_d   = '0;
        state_d      = i_abort ? S_ABORT : S_RUN;
      end

      S_RUN: begin
        o_inst_dval  = 1'b1;
        o_inst_stall = i_stall_req;
        end_seen_d   = end_seen_q | i_confEnd;
        if (i_abort) begin
          state_d = S_ABORT;
        end else if (tile_done) begin
          if (last_tile) begin
            state_d = S_DONE;
          end else begin
            // Index advances on the way into RELOAD so it is visible with that start.
            tile_idx_d = tile_idx_q + NTILEWD'(1);
            state_d    = S_RELOAD;
          end
        end
      end

      S_DONE: begin
        Done_rdy = 1'b1;
        if (Done_ack) state_d = S_IDLE;
      end

      S_ABORT: begin
        o_inst_dval  = 1'b1;
        o_inst_reset = 1'b1;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Tiles restart through start, since PEs fall back to their IDLE on confEnd.
  assign o_inst_next = 1'b0;
  assign o_tile_idx  = tile_idx_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: doc/pe_tile_sequencer.md
# pe_tile_sequencer

Sequences one row of `NPE` PE columns through a multi-tile job by driving their shared instruction bundle (dval/start/reset/next/stall). It accepts a job descriptor over a rdy/ack handshake, issues one start per tile, and collects per-column `confEnd` pulses until every column has finished the tile. It forwards downstream backpressure as stall, and reports completion over a second rdy/ack handshake. It sits between the layer-level controller and the PE row, one instance per row.

## Interface
- `NPE`, 4, number of PE columns sharing the instruction bundle.
- `NTILEWD`, 8, width of the tile count and tile index.

- `i_clk`  in  1  clock.
- `i_rstn`  in  1  synchronous reset, active-low.
- `Job_rdy`  in  1  job descriptor valid.
- `Job_ack`  out  1  job accepted; a transfer occurs when `Job_rdy && Job_ack`.
- `i_job_ntile`  in  `NTILEWD`  tiles in the job; sampled on the job transfer.
- `i_confEnd`  in  `NPE`  per-column single-cycle confEnd pulse.
- `i_stall_req`  in  1  downstream psum buffer full.
- `i_abort`  in  1  abort the current job.
- `o_inst_dval`, `o_inst_start`, `o_inst_reset`, `o_inst_next`, `o_inst_stall`  out  1 each  PE instruction fields.
- `o_tile_idx`  out  `NTILEWD`  index of the current tile, 0-based.
- `o_busy`  out  1  high in every state except IDLE.
- `Done_rdy`  out  1  job complete.
- `Done_ack`  in  1  completion consumed.

## Operation
- FSM states: IDLE, START, RUN, RELOAD, DONE, ABORT. Reset enters IDLE.
- **IDLE**
  - `Job_ack`=1.
  - On a job transfer: latch `ntile` and clear `o_tile_idx`.
  - If `i_job_ntile`=0, go directly to DONE with no PE activity. Otherwise go to START.
- **START**: drive `dval`=1 and `start`=1 for one cycle, clear `end_seen[NPE-1:0]`, then go to RUN.
- **RUN**
  - `dval`=1; `stall` = `i_stall_req` (combinational passthrough); `end_seen` |= `i_confEnd`.
  - Tile complete when `&(end_seen | i_confEnd)`.
  - On tile complete: if `o_tile_idx == ntile-1`, go to DONE; else go to RELOAD.
- **RELOAD**: increment `o_tile_idx` on entry, clear `end_seen`, drive `dval`=1 and `start`=1 for one cycle, then go to RUN. Columns that finished early wait in their IDLE until this start.
- **DONE**: `Done_rdy`=1 and held until `Done_ack`, then go to IDLE. `o_tile_idx` holds the last index.
- **ABORT**
  - `i_abort` in START, RUN or RELOAD transfers to ABORT on the next edge.
  - ABORT drives `dval`=1 and `reset`=1 for one cycle, then goes to IDLE with no Done.
  - `i_abort` in IDLE or DONE is ignored.
- `o_inst_next` is reserved and held at 0 (tiles are restarted with `start`, because PEs return to IDLE on confEnd).
- Instruction fields not listed for a state are 0. `stall` is 0 outside RUN.
- A `confEnd` bit arriving again for an already-seen column is harmless (OR).

## Timing
- Reset values: state IDLE, all `o_inst_*`=0, `o_tile_idx`=0, `o_busy`=0, `Done_rdy`=0, `Job_ack`=1.
- Job transfer at edge T puts the start pulse in cycle T+1 and RUN from T+2.
- Last column's confEnd in cycle T:
  - RELOAD (with its start pulse and the incremented `o_tile_idx`) in cycle T+1.
  - RUN from T+2.
  - Per-tile overhead is 2 cycles.
- Last tile's completion in cycle T gives `Done_rdy`=1 from T+1.
- `Done_ack` in the same cycle `Done_rdy` rises is legal; IDLE (`Job_ack`=1) follows in the next cycle.
- Priority when simultaneous:
  - `i_abort` beats tile complete.
  - Tile complete beats stall; the stall is still passed through in that cycle.
- `o_tile_idx` wraps only through a new job (cleared on acceptance). `ntile`=2^`NTILEWD`-1 must run every tile; the compare uses full width with no overflow.
- Reset low mid-job: next cycle is IDLE with all outputs at reset values; no reset pulse is sent to the PEs.

## Test plan
- **Single tile:** job `ntile`=1, columns pulse confEnd at cycles 10,12,12,15 -> one start pulse, `Done_rdy` at 16, `o_tile_idx`=0.
- **Three tiles:** `ntile`=3, all columns end together each tile -> exactly 3 start pulses, `o_tile_idx` reads 0,1,2, Done after the third end.
- **Stall passthrough:** `i_stall_req` high 5 cycles during RUN -> `o_inst_stall` high in exactly those 5 cycles with `dval`=1; tile count unaffected.
- **Abort mid-tile:** abort in RUN of tile 1 of 3 -> one cycle `dval`=`reset`=1, then IDLE, no `Done_rdy`, `Job_ack`=1.
- **Abort beats end:** abort in the same cycle as the final confEnd -> ABORT path, no Done.
- **Zero tiles and back-to-back:** `ntile`=0 -> Done with no start pulse. A second job offered while `Done_rdy` is held -> not acked until one cycle after `Done_ack`.
